// File: rtl/bm_input_feeder.sv
// Board-side producer for one BondMachine processor input port: buffers board words in a
// small FIFO and hands them out one at a time over the valid/received handshake.
module bm_input_feeder #(
    parameter int WIDTH       = 8,
    parameter int DEPTH_LOG2  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock_signal,
    input  logic                  reset_signal,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [WIDTH-1:0]      i0,
    output logic                  i0_valid,
    input  logic                  i0_received
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, PRESENT, WAIT_RELEASE} state_t;

    state_t                  state, state_next;
    logic                    rcv;
    logic                    pop;
    logic                    clr_valid;
    logic                    wr_accept;
    logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]     level_next;
    logic [WIDTH-1:0]        mem [DEPTH];

    // The acknowledge may come from a slower processor clock domain, so it is delayed
    // through a flop chain unless the caller asks for the raw signal.
    generate
        if (SYNC_STAGES == 0) begin : g_raw
            assign rcv = i0_received;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clock_signal or negedge reset_signal) begin
                if (!reset_signal) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= i0_received;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= sync_q[s-1];
                    end
                end
            end
            assign rcv = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Writes use the registered full, so a write while full is lost even if a pop coincides.
    assign wr_accept = wr_en && !full;

    always_comb begin
        level_next = level;
        case ({wr_accept, pop})
            2'b10:   level_next = level + (DEPTH_LOG2 + 1)'(1);
            2'b01:   level_next = level - (DEPTH_LOG2 + 1)'(1);
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clock_signal) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock_signal or negedge reset_signal) begin
        if (!reset_signal) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)       rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            level    <= level_next;
            full     <= (level_next == DEPTH_LVL);
            empty    <= (level_next == '0);
            overflow <= overflow | (wr_en && full);
        end
    end

    always_ff @(posedge clock_signal or negedge reset_signal) begin
        if (!reset_signal) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // WAIT_RELEASE insists on rcv dropping, so a held-high acknowledge retires one word only.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:         if (!empty && !rcv) state_next = PRESENT;
            PRESENT:      if (rcv)            state_next = WAIT_RELEASE;
            WAIT_RELEASE: if (!rcv)           state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    always_comb begin
        pop       = (state == IDLE) && !empty && !rcv;
        clr_valid = (state == PRESENT) && rcv;
    end

    always_ff @(posedge clock_signal or negedge reset_signal) begin
        if (!reset_signal) begin
            i0       <= '0;
            i0_valid <= 1'b0;
        end else if (pop) begin
            i0       <= mem[rd_ptr];
            i0_valid <= 1'b1;
        end else if (clr_valid) begin
            i0_valid <= 1'b0;
        end
    end

endmodule

// File: doc/bm_input_feeder.md
Name: bm_input_feeder

Overview:
- Board-side producer for one BondMachine processor input port: the transmitting end of the valid/received handshake that processor output ports drive.
- Buffers words from board logic (switches, UART, host glue) in a small FIFO.
- Presents one word at a time on i0 / i0_valid and waits for the processor's i0_received before retiring it.
- Sits in the board top between board logic and the bondmachine instance's input port.

Parameters:
WIDTH, 8, data width of the input port and FIFO entries
DEPTH_LOG2, 2, log2 of FIFO depth (default depth 4)
SYNC_STAGES, 2, flops on i0_received for a slower or divided processor clock; 0 = used directly

Ports:
clock_signal  input  1  board clock; all logic on rising edge
reset_signal  input  1  asynchronous, active-low reset
wr_data  input  WIDTH  word from board logic
wr_en  input  1  write strobe, sampled on rising edge
full  output  1  FIFO full, registered
empty  output  1  FIFO empty, registered
level  output  DEPTH_LOG2+1  FIFO occupancy, excluding the word on i0
overflow  output  1  sticky: a write was dropped
i0  output  WIDTH  word presented to the processor input port
i0_valid  output  1  i0 holds a word not yet consumed
i0_received  input  1  processor acknowledge

Behaviour:
- Reset (reset_signal low, async, immediate):
  - Pointers = 0, level = 0, empty = 1, full = 0, overflow = 0.
  - i0 = 0, i0_valid = 0, sync flops = 0, FSM = IDLE.
  - FIFO contents and any in-flight word are discarded.
- Received path: rcv = i0_received delayed by SYNC_STAGES flops (raw when 0). The FSM uses only rcv.
- FIFO:
  - Circular buffer with DEPTH_LOG2-bit pointers that wrap naturally.
  - full = (level == 2^DEPTH_LOG2); empty = (level == 0).
  - Write accepted when wr_en=1 and full=0, using the registered full.
  - A write while full is dropped even if a pop occurs the same cycle; overflow is set and stays set until reset.
  - Simultaneous accepted write and pop: both occur; level unchanged.
- FSM, 3 states:
  - IDLE: if empty=0 and rcv=0 → i0 <= head, i0_valid <= 1, pop, go PRESENT. Otherwise stay. A spurious rcv=1 in IDLE blocks loading.
  - PRESENT: i0 and i0_valid held stable. On rcv=1 → i0_valid <= 0, go WAIT_RELEASE. i0 keeps its last value.
  - WAIT_RELEASE: on rcv=0 → IDLE. Stays while rcv=1, so a held-high received retires exactly one word.
- Latency:
  - Write sampled at edge E into an empty FIFO in IDLE → i0_valid high after edge E+1.
  - i0_received rising before edge k → i0_valid low after edge k+SYNC_STAGES.
- Throughput: minimum one IDLE cycle between words. Words are delivered in write order with no duplication or loss except dropped overflow writes.
- Capacity: 2^DEPTH_LOG2 buffered words plus one presented word.

Test Plan:
1. Hold reset_signal low 3 cycles with wr_en=1 → i0_valid=0, i0=0, empty=1, level=0, overflow=0; no write retained after release.
2. Write 8'hA5; consumer raises i0_received 3 cycles after i0_valid and drops it 1 cycle after i0_valid falls → i0=8'hA5 with valid rising after edge E+1 and falling 2 edges after received rises (SYNC_STAGES=2); empty=1 at end.
3. Write 8'h01..8'h06 on consecutive cycles, received held 0 → i0=8'h01 valid; full=1, level=4 after the 5th write; 8'h06 dropped, overflow=1. Then acknowledge all → delivered 01,02,03,04,05 in order.
4. Word presented with level=2; write 8'h33 in the same cycle FIFO pops on IDLE load → level stays 2; 8'h33 delivered last.
5. i0_received tied high before the first write, then 2 words written → no word presented; after received goes low, words delivered one per handshake.
6. Assert reset mid-PRESENT with level=3 → i0_valid falls immediately (async); after release, no stale word presented and level=0.
